// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver.
// Synchronises and debounces the PS/2 clock, then shifts in 11-bit frames: start bit,
// 8 data bits LSB first, odd parity and stop. Each received byte is presented with a
// one-cycle done strobe plus parity/stop status. An inter-bit watchdog aborts stalled frames.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset        asynchronous active-low reset
//   ps2d, ps2c   PS/2 data and clock lines (asynchronous)
//   rx_en        allows a new frame to start; does not abort a frame already in progress
//   rx_done_tick one-cycle pulse, frame complete; dout/parity_err/frame_err valid
//   dout         received byte, held until the next rx_done_tick
//   parity_err   with rx_done_tick: odd-parity check failed
//   frame_err    with rx_done_tick: stop bit sampled 0
//   timeout_tick one-cycle pulse, frame aborted by the watchdog
module ps2_rx_frame #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2d,
  input  logic       ps2c,
  input  logic       rx_en,
  output logic       rx_done_tick,
  output logic [7:0] dout,
  output logic       parity_err,
  output logic       frame_err,
  output logic       timeout_tick
);

  localparam int unsigned WdW = $clog2(TIMEOUT_CYC);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StDps, StLoad} state_e;

  // Two-flop synchronisers; both lines idle high.
  logic ps2c_meta_q, ps2c_sync_q, ps2d_meta_q, ps2d_sync_q;

  logic [FILTER_LEN-1:0] filter_q, filter_d;
  logic                  fclk_q, fclk_d;
  logic                  fall_edge;

  state_e         state_q, state_d;
  logic [3:0]     n_q, n_d;
  logic [9:0]     b_q, b_d;
  logic [WdW-1:0] wd_q, wd_d;
  logic [7:0]     dout_q, dout_d;
  logic           perr_q, perr_d;
  logic           ferr_q, ferr_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps2c_meta_q <= 1'b1;
      ps2c_sync_q <= 1'b1;
      ps2d_meta_q <= 1'b1;
      ps2d_sync_q <= 1'b1;
    end else begin
      ps2c_meta_q <= ps2c;
      ps2c_sync_q <= ps2c_meta_q;
      ps2d_meta_q <= ps2d;
      ps2d_sync_q <= ps2d_meta_q;
    end
  end

  // Debounce: the filtered clock only changes once the whole window agrees.
  always_comb begin
    filter_d = {ps2c_sync_q, filter_q[FILTER_LEN-1:1]};
    fclk_d   = fclk_q;
    if (&filter_q) begin
      fclk_d = 1'b1;
    end else if (~|filter_q) begin
      fclk_d = 1'b0;
    end
  end

  assign fall_edge = fclk_q & ~fclk_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filter_q <= '1;
      fclk_q   <= 1'b1;
    end else begin
      filter_q <= filter_d;
      fclk_q   <= fclk_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    b_d          = b_q;
    wd_d         = wd_q;
    dout_d       = dout_q;
    perr_d       = 1'b0;
    ferr_d       = 1'b0;
    timeout_tick = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (fall_edge && rx_en && !ps2d_sync_q) begin
          state_d = StDps;
          n_d     = 4'd9;
          wd_d    = '0;
        end
      end
      StDps: begin
        if (fall_edge) begin
          b_d  = {ps2d_sync_q, b_q[9:1]};
          wd_d = '0;
          if (n_q == 4'd0) begin
            // Capture result on entry to StLoad so it is valid alongside the done strobe.
            state_d = StLoad;
            dout_d  = b_d[7:0];
            perr_d  = ~^b_d[8:0];
            ferr_d  = ~b_d[9];
          end else begin
            n_d = n_q - 4'd1;
          end
        end else if (wd_q == WdLast) begin
          state_d      = StIdle;
          timeout_tick = 1'b1;
        end else if (wd_q != '1) begin
          wd_d = wd_q + WdW'(1);
        end
      end
      StLoad: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      n_q     <= '0;
      b_q     <= '0;
      wd_q    <= '0;
      dout_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      b_q     <= b_d;
      wd_q    <= wd_d;
      dout_q  <= dout_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_done_tick = (state_q == StLoad);
  assign dout         = dout_q;
  assign parity_err   = perr_q;
  assign frame_err    = ferr_q;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Bench for ps2_rx_frame: directed table vectors, randomized frames against a behavioural
// frame model, and hand-written glitch / rx_en / timeout / reset sequences.
module tb_ps2_rx_frame;

  localparam int unsigned FL = 8;
  localparam int unsigned TO = 2000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2d = 1'b1;
  logic       ps2c = 1'b1;
  logic       rx_en = 1'b0;
  logic       rx_done_tick;
  logic [7:0] dout;
  logic       parity_err;
  logic       frame_err;
  logic       timeout_tick;

  ps2_rx_frame #(
    .FILTER_LEN (FL),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2d        (ps2d),
    .ps2c        (ps2c),
    .rx_en       (rx_en),
    .rx_done_tick(rx_done_tick),
    .dout        (dout),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .timeout_tick(timeout_tick)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       f;
  } res_t;

  res_t        got_q[$];
  int          done_cnt   = 0;
  int          to_cnt     = 0;
  int          flag_viol  = 0;
  int          width_viol = 0;
  int unsigned to_cyc     = 0;
  int unsigned last_fall  = 0;
  logic        prev_done  = 1'b0;
  logic        prev_to    = 1'b0;

  int checks = 0;
  int errors = 0;

  // Output monitor.
  always @(negedge clk) begin
    if (reset) begin
      if (rx_done_tick) begin
        res_t r;
        r.d = dout;
        r.p = parity_err;
        r.f = frame_err;
        got_q.push_back(r);
        done_cnt++;
      end
      if (timeout_tick) begin
        to_cnt++;
        to_cyc = cyc;
      end
      if (!rx_done_tick && (parity_err || frame_err)) flag_viol++;
      if ((rx_done_tick && prev_done) || (timeout_tick && prev_to)) width_viol++;
    end
    prev_done = rx_done_tick;
    prev_to   = timeout_tick;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2d = b;
    wait_cyc(20);
    ps2c = 1'b0;
    last_fall = cyc;
    wait_cyc(40);
    ps2c = 1'b1;
    wait_cyc(20);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input logic drop_en);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      send_bit(bits[i]);
      if (i == 0 && drop_en) rx_en = 1'b0;
    end
    ps2d = 1'b1;
    wait_cyc(40);
    if (drop_en) rx_en = 1'b1;
  endtask

  task automatic check_frame(input string name, input logic [7:0] d, input logic p,
                             input logic s, input logic drop_en, input logic [7:0] exp_d,
                             input logic exp_p, input logic exp_f);
    int   c0;
    res_t r;
    c0 = done_cnt;
    got_q.delete();
    send_frame(d, p, s, drop_en);
    chk({name, " done_count"}, done_cnt - c0, 1);
    if (got_q.size() > 0) begin
      r = got_q.pop_front();
      chk({name, " dout"}, r.d, exp_d);
      chk({name, " parity_err"}, r.p, exp_p);
      chk({name, " frame_err"}, r.f, exp_f);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       s;
    logic [7:0] exp_d;
    logic       exp_p;
    logic       exp_f;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #10000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench stalled");
  end

  initial begin
    logic [7:0]  last_dout;
    logic [7:0]  rd;
    logic        rp, rs, rdrop, exp_p;
    int          c0, t0, guard;
    int unsigned delta;

    vecs[0] = '{8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0};
    vecs[1] = '{8'hF0, 1'b0, 1'b1, 8'hF0, 1'b1, 1'b0};
    vecs[2] = '{8'h5A, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1};

    // Reset state.
    wait_cyc(3);
    chk("reset outputs", {23'd0, rx_done_tick, parity_err, frame_err, timeout_tick, dout}, 0);
    reset = 1'b1;
    rx_en = 1'b1;
    wait_cyc(5);

    foreach (vecs[i]) begin
      check_frame($sformatf("vec%0d", i), vecs[i].d, vecs[i].p, vecs[i].s, 1'b0,
                  vecs[i].exp_d, vecs[i].exp_p, vecs[i].exp_f);
    end
    last_dout = 8'hFF;

    // Random frames against the frame model: odd parity over data+parity bit, stop must be 1.
    for (int i = 0; i < 14; i++) begin
      rd    = 8'($urandom);
      rp    = ($urandom_range(0, 3) == 0) ? (^rd) : ~(^rd);
      rs    = ($urandom_range(0, 4) != 0);
      rdrop = ($urandom_range(0, 2) == 0);
      exp_p = ((($countones(rd) + int'(rp)) % 2) == 0);
      check_frame($sformatf("rand%0d", i), rd, rp, rs, rdrop, rd, exp_p, ~rs);
      last_dout = rd;
    end

    // Short ps2c glitches and a whole frame offered with rx_en low.
    c0 = done_cnt;
    t0 = to_cnt;
    for (int i = 0; i < 3; i++) begin
      ps2c = 1'b0;
      wait_cyc(3);
      ps2c = 1'b1;
      wait_cyc(30);
    end
    rx_en = 1'b0;
    send_frame(8'h33, 1'b1, 1'b1, 1'b0);
    rx_en = 1'b1;
    wait_cyc(20);
    chk("glitch/rx_en no done", done_cnt - c0, 0);
    chk("glitch/rx_en dout held", dout, last_dout);
    chk("glitch/rx_en no timeout", to_cnt - t0, 0);

    // Stall after 5 data bits.
    c0 = done_cnt;
    t0 = to_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    guard = 0;
    while (to_cnt == t0 && guard < 2300) begin
      wait_cyc(1);
      guard++;
    end
    wait_cyc(100);
    delta = to_cyc - last_fall;
    chk("timeout count", to_cnt - t0, 1);
    chk("timeout delay window", 32'((delta >= 2 + FL + TO - 2) && (delta <= 2 + FL + TO + 2)), 1);
    chk("timeout no done", done_cnt - c0, 0);
    chk("timeout dout held", dout, last_dout);
    check_frame("after timeout", 8'h29, 1'b0, 1'b1, 1'b0, 8'h29, 1'b0, 1'b0);

    // Reset mid-frame.
    c0 = done_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_cyc(1);
      chk($sformatf("mid-frame reset outputs %0d", i),
          {23'd0, rx_done_tick, parity_err, frame_err, timeout_tick, dout}, 0);
    end
    reset = 1'b1;
    ps2d  = 1'b1;
    wait_cyc(20);
    chk("reset partial discarded", done_cnt - c0, 0);
    check_frame("after reset", 8'h76, 1'b0, 1'b1, 1'b0, 8'h76, 1'b0, 1'b0);

    wait_cyc(50);
    chk("flags outside done", flag_viol, 0);
    chk("pulse width", width_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
